// File: rtl/touch_pkg.sv
// Shared types and constants for the touch gesture controller.
// Optional long-press support is controlled by TOUCH_GESTURE_LONG_PRESS_EN.
package touch_pkg;

  // Gesture FSM states
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARM1     = 3'd1,
    ARM2     = 3'd2,
    HOLD     = 3'd3,
    WAIT_REL = 3'd4
  } state_t;

  // Event codes presented on evt_code
  localparam logic [1:0] EVT_SINGLE1 = 2'd0;
  localparam logic [1:0] EVT_SINGLE2 = 2'd1;
  localparam logic [1:0] EVT_BOTH    = 2'd2;
  localparam logic [1:0] EVT_LONG    = 2'd3;

  // Default timing in clock cycles
  localparam int unsigned DEF_DEB_CYCLES  = 50000;
  localparam int unsigned DEF_WIN_CYCLES  = 5000000;
  localparam int unsigned DEF_HOLD_CYCLES = 2500000;
  localparam int unsigned DEF_LONG_CYCLES = 100000000;

  // Counter width for a cycle budget, never narrower than one bit
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/touch_debounce.sv
// Two-flop synchroniser followed by a stable-level debounce counter.
module touch_debounce
  import touch_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  localparam int unsigned DW = cnt_w(DEB_CYCLES);

  logic          sync1;
  logic          sync2;
  logic [DW-1:0] cnt;

  // Bring the asynchronous sensor into the clock domain
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Toggle the clean level only after the synced input has disagreed long enough
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync2 == level) begin
      cnt <= '0;
    end else if (cnt == DW'(DEB_CYCLES - 1)) begin
      cnt   <= '0;
      level <= ~level;
    end else begin
      cnt <= cnt + DW'(1);
    end
  end

endmodule

// File: rtl/touch_gesture_ctrl.sv
// Two-sensor touch gesture classifier with a single-entry event buffer.
// Define TOUCH_GESTURE_LONG_PRESS_EN to add the LONG event after a BOTH hold.
module touch_gesture_ctrl
  import touch_pkg::*;
#(
  parameter int unsigned DEB_CYCLES  = DEF_DEB_CYCLES,
  parameter int unsigned WIN_CYCLES  = DEF_WIN_CYCLES,
  parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int unsigned LONG_CYCLES = DEF_LONG_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       touch1,
  input  logic       touch2,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [1:0] evt_code,
  output logic       evt_drop,
  output logic       touched,
  output logic [2:0] state_dbg
);

  localparam int unsigned WIN_W  = cnt_w(WIN_CYCLES);
  localparam int unsigned HOLD_W = cnt_w(HOLD_CYCLES);

  logic db1, db2, db1_q, db2_q;
  logic rise1, rise2, fall1, fall2;

  state_t            state, state_n;
  logic [WIN_W-1:0]  win_cnt, win_cnt_n;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_n;
  logic              emit_c;
  logic [1:0]        emit_code_c;

`ifdef TOUCH_GESTURE_LONG_PRESS_EN
  localparam int unsigned LONG_W = cnt_w(LONG_CYCLES);
  logic              long_arm, long_arm_n;
  logic [LONG_W-1:0] long_cnt, long_cnt_n;
`else
  logic unused_long;
  assign unused_long = (LONG_CYCLES == 0) | (emit_code_c == EVT_LONG);
`endif

  touch_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb1 (
    .clk   (clk),
    .rst   (rst),
    .raw   (touch1),
    .level (db1)
  );

  touch_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb2 (
    .clk   (clk),
    .rst   (rst),
    .raw   (touch2),
    .level (db2)
  );

  // Registered edges of the debounced levels and the both-touched level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db1_q   <= 1'b0;
      db2_q   <= 1'b0;
      rise1   <= 1'b0;
      rise2   <= 1'b0;
      fall1   <= 1'b0;
      fall2   <= 1'b0;
      touched <= 1'b0;
    end else begin
      db1_q   <= db1;
      db2_q   <= db2;
      rise1   <= db1 & ~db1_q;
      rise2   <= db2 & ~db2_q;
      fall1   <= ~db1 & db1_q;
      fall2   <= ~db2 & db2_q;
      touched <= db1 & db2;
    end
  end

  // FSM state and gesture counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      win_cnt  <= '0;
      hold_cnt <= '0;
`ifdef TOUCH_GESTURE_LONG_PRESS_EN
      long_arm <= 1'b0;
      long_cnt <= '0;
`endif
    end else begin
      state    <= state_n;
      win_cnt  <= win_cnt_n;
      hold_cnt <= hold_cnt_n;
`ifdef TOUCH_GESTURE_LONG_PRESS_EN
      long_arm <= long_arm_n;
      long_cnt <= long_cnt_n;
`endif
    end
  end

  // Gesture classification; emit_c marks the deciding cycle
  always_comb begin
    state_n     = state;
    win_cnt_n   = win_cnt;
    hold_cnt_n  = hold_cnt;
    emit_c      = 1'b0;
    emit_code_c = EVT_SINGLE1;
`ifdef TOUCH_GESTURE_LONG_PRESS_EN
    long_arm_n  = long_arm;
    long_cnt_n  = long_cnt;
`endif
    case (state)
      IDLE: begin
        if (rise1 && rise2) begin
          state_n    = HOLD;
          hold_cnt_n = '0;
        end else if (rise1) begin
          state_n   = ARM1;
          win_cnt_n = '0;
        end else if (rise2) begin
          state_n   = ARM2;
          win_cnt_n = '0;
        end
      end
      ARM1: begin
        if (fall1) begin
          emit_c      = 1'b1;
          emit_code_c = EVT_SINGLE1;
          state_n     = WAIT_REL;
        end else if (rise2) begin
          state_n    = HOLD;
          hold_cnt_n = '0;
        end else if (win_cnt == WIN_W'(WIN_CYCLES - 1)) begin
          emit_c      = 1'b1;
          emit_code_c = EVT_SINGLE1;
          state_n     = WAIT_REL;
        end else begin
          win_cnt_n = win_cnt + WIN_W'(1);
        end
      end
      ARM2: begin
        if (fall2) begin
          emit_c      = 1'b1;
          emit_code_c = EVT_SINGLE2;
          state_n     = WAIT_REL;
        end else if (rise1) begin
          state_n    = HOLD;
          hold_cnt_n = '0;
        end else if (win_cnt == WIN_W'(WIN_CYCLES - 1)) begin
          emit_c      = 1'b1;
          emit_code_c = EVT_SINGLE2;
          state_n     = WAIT_REL;
        end else begin
          win_cnt_n = win_cnt + WIN_W'(1);
        end
      end
      HOLD: begin
        if (fall1 || fall2) begin
          state_n = WAIT_REL;
        end else if (hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) begin
          emit_c      = 1'b1;
          emit_code_c = EVT_BOTH;
          state_n     = WAIT_REL;
`ifdef TOUCH_GESTURE_LONG_PRESS_EN
          long_arm_n  = 1'b1;
          long_cnt_n  = '0;
`endif
        end else begin
          hold_cnt_n = hold_cnt + HOLD_W'(1);
        end
      end
      WAIT_REL: begin
`ifdef TOUCH_GESTURE_LONG_PRESS_EN
        if (long_arm) begin
          if (fall1 || fall2) begin
            long_arm_n = 1'b0;
          end else if (long_cnt == LONG_W'(LONG_CYCLES - 1)) begin
            emit_c      = 1'b1;
            emit_code_c = EVT_LONG;
            long_arm_n  = 1'b0;
          end else begin
            long_cnt_n = long_cnt + LONG_W'(1);
          end
        end
`endif
        if (!db1 && !db2) begin
          state_n = IDLE;
`ifdef TOUCH_GESTURE_LONG_PRESS_EN
          long_arm_n = 1'b0;
`endif
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign state_dbg = state;

  // Single-entry event buffer; a new event while full and stalled is dropped
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      evt_valid <= 1'b0;
      evt_code  <= 2'd0;
      evt_drop  <= 1'b0;
    end else begin
      evt_drop <= 1'b0;
      if (emit_c) begin
        if (!evt_valid || evt_ready) begin
          evt_valid <= 1'b1;
          evt_code  <= emit_code_c;
        end else begin
          evt_drop <= 1'b1;
        end
      end else if (evt_ready) begin
        evt_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_touch_gesture_ctrl.sv
// Self-checking bench: behavioural gesture model compared every cycle,
// directed scenarios with literal expectations, then random stimulus.
module tb_touch_gesture_ctrl;

  localparam int DEB  = 4;
  localparam int WIN  = 20;
  localparam int HOLD = 10;
  localparam int LONG = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       touch1 = 1'b0;
  logic       touch2 = 1'b0;
  logic       evt_ready = 1'b0;
  logic       evt_valid;
  logic [1:0] evt_code;
  logic       evt_drop;
  logic       touched;
  logic [2:0] state_dbg;

  always #5 clk = ~clk;

  touch_gesture_ctrl #(
    .DEB_CYCLES (DEB),
    .WIN_CYCLES (WIN),
    .HOLD_CYCLES(HOLD),
    .LONG_CYCLES(LONG)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .touch1   (touch1),
    .touch2   (touch2),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_code (evt_code),
    .evt_drop (evt_drop),
    .touched  (touched),
    .state_dbg(state_dbg)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // States: 0 idle, 1/2 armed by sensor 1/2, 3 both held, 4 wait for release
  int cyc;
  bit ms1[2], ms2[2], mdb[2], mdbq[2], mrise[2], mfall[2];
  int mrun[2];
  int mst, t_enter, t_long;
  bit m_arm, mv, mdrop, mtouch;
  int mcode;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      ms1[i] = 0; ms2[i] = 0; mdb[i] = 0; mdbq[i] = 0;
      mrise[i] = 0; mfall[i] = 0; mrun[i] = 0;
    end
    mst = 0; t_enter = cyc; t_long = 0; m_arm = 0;
    mv = 0; mdrop = 0; mtouch = 0; mcode = 0;
  endtask

  task automatic model_step(input bit r1, input bit r2, input bit rdy);
    bit raw[2];
    bit n_db[2];
    int n_run[2];
    int nst, emit, age, x, o, n_tlong;
    bit n_arm;
    raw[0] = r1; raw[1] = r2;
    // a clean level flips once the synced input has disagreed DEB cycles in a row
    for (int i = 0; i < 2; i++) begin
      n_db[i] = mdb[i];
      n_run[i] = 0;
      if (ms2[i] != mdb[i]) begin
        if (mrun[i] + 1 >= DEB) n_db[i] = !mdb[i];
        else n_run[i] = mrun[i] + 1;
      end
    end
    age = cyc - t_enter;
    nst = mst; emit = -1; n_arm = m_arm; n_tlong = t_long;
    case (mst)
      0: begin
        if (mrise[0] && mrise[1]) nst = 3;
        else if (mrise[0]) nst = 1;
        else if (mrise[1]) nst = 2;
      end
      1, 2: begin
        x = mst - 1; o = 1 - x;
        if (mfall[x]) begin emit = x; nst = 4; end
        else if (mrise[o]) nst = 3;
        else if (age >= WIN - 1) begin emit = x; nst = 4; end
      end
      3: begin
        if (mfall[0] || mfall[1]) nst = 4;
        else if (age >= HOLD - 1) begin
          emit = 2; nst = 4; n_arm = 1; n_tlong = cyc + 1;
        end
      end
      default: begin
`ifdef TOUCH_GESTURE_LONG_PRESS_EN
        if (m_arm) begin
          if (mfall[0] || mfall[1]) n_arm = 0;
          else if (cyc - t_long >= LONG - 1) begin emit = 3; n_arm = 0; end
        end
`endif
        if (!mdb[0] && !mdb[1]) begin nst = 0; n_arm = 0; end
      end
    endcase
    // single-entry buffer
    mdrop = 0;
    if (emit >= 0) begin
      if (!mv || rdy) begin mv = 1; mcode = emit; end
      else mdrop = 1;
    end else if (mv && rdy) mv = 0;
    if (nst != mst) t_enter = cyc + 1;
    mst = nst; m_arm = n_arm; t_long = n_tlong;
    mtouch = mdb[0] && mdb[1];
    for (int i = 0; i < 2; i++) begin
      mrise[i] = mdb[i] && !mdbq[i];
      mfall[i] = !mdb[i] && mdbq[i];
      mdbq[i] = mdb[i];
      mdb[i] = n_db[i];
      mrun[i] = n_run[i];
      ms2[i] = ms1[i];
      ms1[i] = raw[i];
    end
    cyc++;
  endtask

  // ---------------- monitor / compare ----------------
  int obs[$];
  int drops;
  bit saw_wait;

  initial begin
    cyc = 0;
    drops = 0;
    saw_wait = 0;
    model_reset();
    forever begin
      @(posedge clk);
      if (rst) model_step(touch1, touch2, evt_ready);
      else model_reset();
      @(negedge clk);
      if (!rst) model_reset();
      check("touched", int'(touched), int'(mtouch));
      check("state_dbg", int'(state_dbg), mst);
      check("evt_valid", int'(evt_valid), int'(mv));
      if (mv) check("evt_code", int'(evt_code), mcode);
      check("evt_drop", int'(evt_drop), int'(mdrop));
      if (evt_drop) drops++;
      if (state_dbg == 3'd4) saw_wait = 1;
      if (evt_valid && evt_ready) obs.push_back(int'(evt_code));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int ev(input int idx);
    return (obs.size() > idx) ? obs[idx] : -1;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    tick(3);
    check("rst_valid", int'(evt_valid), 0);
    check("rst_code", int'(evt_code), 0);
    check("rst_drop", int'(evt_drop), 0);
    check("rst_touched", int'(touched), 0);
    check("rst_state", int'(state_dbg), 0);
    rst = 1'b1;
    tick(2);

    // glitch shorter than the debounce
    obs.delete();
    touch1 = 1; tick(3); touch1 = 0; tick(15);
    check("glitch_events", obs.size(), 0);
    check("glitch_touched", int'(touched), 0);
    check("glitch_state", int'(state_dbg), 0);

    // single tap
    evt_ready = 1; obs.delete();
    touch1 = 1; tick(15); touch1 = 0; tick(20);
    check("tap_count", obs.size(), 1);
    check("tap_code", ev(0), 0);
    check("tap_state", int'(state_dbg), 0);

    // two-hand gesture inside the window
    obs.delete();
    touch1 = 1; tick(8); touch2 = 1; tick(30);
    check("both_touched", int'(touched), 1);
    touch1 = 0; touch2 = 0; tick(20);
    check("both_count", obs.size(), 1);
    check("both_code", ev(0), 2);

    // second sensor too late
    obs.delete();
    touch1 = 1; tick(25); touch2 = 1; tick(10);
    touch1 = 0; touch2 = 0; tick(20);
    check("late_count", obs.size(), 1);
    check("late_code", ev(0), 0);

    // early release during hold
    obs.delete(); saw_wait = 0;
    touch1 = 1; touch2 = 1; tick(5); touch2 = 0; tick(5); touch1 = 0; tick(20);
    check("early_count", obs.size(), 0);
    check("early_waitrel", int'(saw_wait), 1);
    check("early_state", int'(state_dbg), 0);

    // backpressure: second event dropped
    evt_ready = 0; obs.delete(); drops = 0;
    touch1 = 1; tick(10); touch1 = 0; tick(15);
    touch2 = 1; tick(10); touch2 = 0; tick(15);
    check("bp_valid", int'(evt_valid), 1);
    check("bp_code", int'(evt_code), 0);
    check("bp_drops", drops, 1);
    evt_ready = 1; tick(3);
    check("bp_count", obs.size(), 1);
    check("bp_xfer", ev(0), 0);

    // long hold
    obs.delete();
    touch1 = 1; touch2 = 1; tick(60); touch1 = 0; touch2 = 0; tick(20);
`ifdef TOUCH_GESTURE_LONG_PRESS_EN
    check("long_count", obs.size(), 2);
    check("long_first", ev(0), 2);
    check("long_second", ev(1), 3);
`else
    check("long_count", obs.size(), 1);
    check("long_first", ev(0), 2);
`endif

    // reset with a pending event clears evt_valid at once
    evt_ready = 0;
    touch1 = 1; tick(12); touch1 = 0; tick(15);
    check("pend_valid", int'(evt_valid), 1);
    #1 rst = 0; #1;
    check("async_valid", int'(evt_valid), 0);
    check("async_state", int'(state_dbg), 0);
    tick(2); rst = 1; tick(2);

    // random stimulus against the model
    for (int seg = 0; seg < 160; seg++) begin
      touch1 = 1'($urandom_range(0, 1));
      touch2 = 1'($urandom_range(0, 1));
      evt_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 60) == 0) begin
        rst = 0; tick(2); rst = 1;
      end
      tick($urandom_range(1, 35));
    end

    touch1 = 0; touch2 = 0; evt_ready = 1; tick(30);
    check("final_state", int'(state_dbg), 0);
    check("final_valid", int'(evt_valid), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/touch_gesture_ctrl.md
Name: touch_gesture_ctrl

Overview:
- Sequences the two capacitive touch inputs feeding the touch sensor side module.
- Synchronises and debounces each raw input, then runs a gesture FSM that classifies single-sensor taps and a deliberate two-hand hold.
- Delivers one event at a time to the main controller over a valid/ready handshake.
- Also exports a clean debounced "both touched" level.

Parameters:
- DEB_CYCLES, 50000: consecutive stable cycles required before a debounced level changes.
- WIN_CYCLES, 5000000: maximum cycles between the first and second sensor press for a two-hand gesture.
- HOLD_CYCLES, 2500000: cycles both sensors must stay pressed before a BOTH event is emitted.
- LONG_CYCLES, 100000000: extra hold cycles after BOTH before a LONG event is emitted (optional feature only).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset (rst==0 resets)
- touch1  in  1  raw sensor 1, asynchronous
- touch2  in  1  raw sensor 2, asynchronous
- evt_valid  out  1  event available
- evt_ready  in  1  consumer accepts the event
- evt_code  out  2  0=SINGLE1, 1=SINGLE2, 2=BOTH, 3=LONG
- evt_drop  out  1  one-cycle pulse: an event was discarded because the buffer was full
- touched  out  1  debounced t1_db & t2_db
- state_dbg  out  3  current FSM state encoding

Behaviour:
- Reset (async assert, sync-safe deassert via clk): FSM=IDLE, debounced levels 0, all counters 0, every output 0.
- Input path, per sensor:
  - 2-FF synchroniser, then debounce counter.
  - Counter clears whenever the synchronised level equals the debounced level.
  - Otherwise it increments; on reaching DEB_CYCLES-1 the debounced level toggles and the counter clears.
  - Latency from a stable raw edge to the debounced edge is 2+DEB_CYCLES cycles.
- Counter widths are $clog2 of their parameter (minimum 1). Counters saturate and never wrap.
- Rising/falling edges are taken from the debounced levels, registered one cycle.
- FSM states and transitions:
  - IDLE: both rise in the same cycle -> HOLD. One rises -> ARM1 or ARM2, window counter cleared.
  - ARMx: the other sensor rises while the window counter < WIN_CYCLES -> HOLD.
  - ARMx: sensor x falls first -> emit SINGLEx -> WAIT_REL.
  - ARMx: window expires with x still held -> emit SINGLEx -> WAIT_REL.
  - HOLD: hold counter reaches HOLD_CYCLES with both still high -> emit BOTH -> WAIT_REL.
  - HOLD: either sensor falls earlier -> WAIT_REL, no event.
  - WAIT_REL: stay until both debounced levels are 0 -> IDLE. This guarantees no event without a full release.
- Emit timing: the event is registered one cycle after the deciding condition.
- Event buffer (single entry):
  - Emit with buffer empty: load code, evt_valid=1 next cycle.
  - evt_code is held stable while evt_valid=1.
  - Transfer occurs on evt_valid & evt_ready.
  - Emit in the same cycle as a transfer: the new code loads and evt_valid stays 1.
  - Emit with buffer full and no transfer: the new event is dropped and evt_drop pulses for 1 cycle.
- Reset mid-gesture: pending event lost, evt_valid low immediately (async).

Optional Feature:
- Macro TOUCH_GESTURE_LONG_PRESS_EN.
- When defined:
  - In WAIT_REL entered via BOTH, a long counter runs while both sensors stay high.
  - On reaching LONG_CYCLES it emits LONG (code 3) exactly once.
  - Any release stops the counter without emitting.
- When undefined: long counter logic is absent, code 3 is never produced, and the LONG_CYCLES parameter is ignored.

Decomposition:
- Package touch_pkg:
  - FSM state enum (IDLE, ARM1, ARM2, HOLD, WAIT_REL).
  - Event code constants EVT_SINGLE1/EVT_SINGLE2/EVT_BOTH/EVT_LONG.
  - Default timing constants.
- Sub-module touch_debounce (parameter DEB_CYCLES; ports: clk, rst, raw, level) contains synchroniser plus debounce counter. Instantiated twice.
- FSM and event buffer stay in touch_gesture_ctrl.

Test Plan:
All scenarios use DEB=4, WIN=20, HOLD=10, LONG=40.
1. Reset and glitch filtering: hold rst=0 -> all outputs 0. Release rst, pulse touch1 high for 3 cycles -> touched=0, no event, state stays IDLE.
2. Single tap: touch1 high 15 cycles, then low; evt_ready=1 -> exactly one evt_valid cycle with evt_code=0, then IDLE after release.
3. Two-hand gesture: touch1 rise, touch2 rise 8 cycles later, hold 30 cycles -> touched=1 and one BOTH (code 2). Repeat with touch2 rising 25 cycles later -> SINGLE1 instead.
4. Early release: both rise together, touch2 falls after 5 cycles -> no event, FSM passes WAIT_REL -> IDLE.
5. Backpressure: evt_ready=0, produce SINGLE1 then SINGLE2 -> evt_code stays 0, evt_drop pulses once. Raise evt_ready -> single transfer of code 0.
6. Optional feature: with TOUCH_GESTURE_LONG_PRESS_EN, hold both 60 cycles -> BOTH then LONG (code 3), once each. Without the macro -> BOTH only.
